// File: rtl/mips_isa_pkg.sv
// Shared ISA definitions for the program loader: opcodes, request kinds, loader states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;

  // Symbolic instruction kinds; encodings 6 and 7 are illegal.
  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_BEQ  = 3'd1,
    KIND_BNE  = 3'd2,
    KIND_ADDI = 3'd3,
    KIND_LUI  = 3'd4,
    KIND_ORI  = 3'd5
  } kind_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loader_state_t;

  // Raw request fields; kind is kept as plain bits so illegal codes survive.
  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
  } instr_req_t;

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_word_encoder.sv
// Maps a symbolic request (kind + fields) to a 32-bit MIPS word and an illegal-kind flag.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module instr_word_encoder
  import mips_isa_pkg::*;
(
  input  instr_req_t  req,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the instruction format from the kind; unknown kinds produce a zero word.
  always_comb begin
    word    = 32'd0;
    illegal = 1'b0;
    case (req.kind)
      KIND_R:    word = {OP_RTYPE, req.rs, req.rt, req.rd, 5'd0, req.funct};
      KIND_BEQ:  word = i_type(OP_BEQ, req.rs, req.rt, req.imm);
      KIND_BNE:  word = i_type(OP_BNE, req.rs, req.rt, req.imm);
      KIND_ADDI: word = i_type(OP_ADDI, req.rs, req.rt, req.imm);
      KIND_LUI:  word = i_type(OP_LUI, 5'd0, req.rt, req.imm);
      KIND_ORI:  word = i_type(OP_ORI, req.rs, req.rt, req.imm);
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instruction requests and writes them sequentially into instruction memory.
// Latency: one cycle from request handshake to the memory write strobe.
// Backpressure: req_ready_o is low outside LOAD and once DEPTH words are accepted (pending included).
// Optional: define LOADER_CHECKSUM_EN to build a running XOR of written words on checksum_o.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              finish_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        kind_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [5:0]        funct_i,
  input  logic [15:0]       imm_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              full_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       checksum_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  loader_state_t    state_q;
  instr_req_t       req;
  logic [31:0]      enc_word;
  logic             enc_illegal;
  logic             accept;
  logic             push;
  logic             bad_kind;
  logic [CNT_W-1:0] count_next;
  logic             reach_full;
  logic             stay_load;
  logic             has_room;

  assign req = '{kind: kind_i, rs: rs_i, rt: rt_i, rd: rd_i, funct: funct_i, imm: imm_i};

  instr_word_encoder u_enc (
    .req     (req),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // Next-cycle bookkeeping: handshake, count after this cycle's write, and room for another word.
  always_comb begin
    accept     = req_ready_o & req_valid_i;
    push       = accept & ~enc_illegal;
    bad_kind   = accept & enc_illegal;
    count_next = start_i ? '0 : word_count_o + CNT_W'(wr_en_o);
    reach_full = (count_next == DEPTH_C);
    stay_load  = start_i | ((state_q == ST_LOAD) & ~finish_i & ~reach_full);
    has_room   = ({1'b0, count_next} + (CNT_W+1)'(push)) < {1'b0, DEPTH_C};
  end

  // Loader FSM with registered handshake, write pipeline, count and status flags.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      req_ready_o  <= 1'b0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= 32'd0;
      word_count_o <= '0;
      full_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      req_ready_o  <= stay_load & has_room;
      wr_en_o      <= push;
      word_count_o <= count_next;
      full_o       <= reach_full;
      if (push) begin
        // The word lands at the count it will see in its write cycle.
        wr_addr_o <= count_next[ADDR_W-1:0];
        wr_data_o <= enc_word;
      end
      if (start_i) begin
        err_o <= bad_kind;
      end else if (bad_kind) begin
        err_o <= 1'b1;
      end
      case (state_q)
        ST_LOAD: begin
          if (start_i) begin
            state_q <= ST_LOAD;
          end else if (finish_i || reach_full) begin
            state_q <= ST_DONE;
            done_o  <= 1'b1;
          end
        end
        default: begin
          if (start_i) begin
            state_q <= ST_LOAD;
            done_o  <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q;

  // Running XOR of every word written since the last start.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      csum_q <= 32'd0;
    end else if (start_i) begin
      csum_q <= 32'd0;
    end else if (wr_en_o) begin
      csum_q <= csum_q ^ wr_data_o;
    end
  end

  assign checksum_o = csum_q;
`else
  assign checksum_o = 32'd0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed bench for instr_encoder_loader against a transaction-level model.
// Latency: model expects each accepted legal request to appear as a write one cycle later.
// Backpressure: model derives readiness from words accepted versus DEPTH.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              finish;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        kind;
  logic [4:0]        rs, rt, rd;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   word_count;
  logic              full, done, err;
  logic [31:0]       checksum;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // model state
  bit          m_loading;
  int          m_written;
  bit          m_pend;
  int          m_addr;
  logic [31:0] m_data;
  bit          m_err;
  bit          m_done;
  logic [31:0] m_csum;
  bit          last_acc;

  // observed writes
  int          log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  bit          log_done[$];

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .start_i      (start),
    .finish_i     (finish),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .kind_i       (kind),
    .rs_i         (rs),
    .rt_i         (rt),
    .rd_i         (rd),
    .funct_i      (funct),
    .imm_i        (imm),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .word_count_o (word_count),
    .full_o       (full),
    .done_o       (done),
    .err_o        (err),
    .checksum_o   (checksum)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // MIPS encoding straight from the field layout.
  function automatic logic [31:0] ref_word(int k, int s, int t, int d, int f, int i);
    int op;
    if (k == 0) return (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | 32'(f);
    case (k)
      1:       op = 4;
      2:       op = 5;
      3:       op = 8;
      4:       begin op = 15; s = 0; end
      default: op = 13;
    endcase
    return (32'(op) << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(i);
  endfunction

  function automatic logic [31:0] exp_csum(input logic [31:0] c);
`ifdef LOADER_CHECKSUM_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction

  function automatic bit model_ready();
    return m_loading && ((m_written + int'(m_pend)) < DEPTH);
  endfunction

  task automatic model_reset();
    m_loading = 0; m_written = 0; m_pend = 0; m_addr = 0; m_data = 32'd0;
    m_err = 0; m_done = 0; m_csum = 32'd0; last_acc = 0;
  endtask

  task automatic check_outputs();
    chk("wr_en", 32'(wr_en), 32'(m_pend));
    if (m_pend) begin
      chk("wr_addr", 32'(wr_addr), 32'(m_addr));
      chk("wr_data", wr_data, m_data);
    end
    chk("ready", 32'(req_ready), 32'(model_ready()));
    chk("count", 32'(word_count), 32'(m_written));
    chk("full", 32'(full), 32'(m_written == DEPTH));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
    chk("checksum", checksum, exp_csum(m_csum));
  endtask

  // Advance the model across the coming clock edge using the inputs now applied.
  task automatic model_step();
    bit acc;
    bit was_loading;
    acc = req_valid && model_ready();
    last_acc = acc;
    was_loading = m_loading;
    if (m_pend) begin
      m_csum = m_csum ^ m_data;
      m_written++;
    end
    m_pend = 0;
    if (start) begin
      m_loading = 1; m_written = 0; m_err = 0; m_csum = 32'd0; m_done = 0;
    end
    if (acc) begin
      if (int'(kind) <= 5) begin
        m_pend = 1;
        m_addr = m_written;
        m_data = ref_word(int'(kind), int'(rs), int'(rt), int'(rd), int'(funct), int'(imm));
      end else begin
        m_err = 1;
      end
    end
    if (!start && was_loading && (finish || m_written == DEPTH)) begin
      m_loading = 0;
      m_done = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
      check_outputs();
    end else begin
      check_outputs();
      if (wr_en) begin
        log_addr.push_back(int'(wr_addr));
        log_data.push_back(wr_data);
        log_cyc.push_back(cyc);
        log_done.push_back(done);
      end
      model_step();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete(); log_data.delete(); log_cyc.delete(); log_done.delete();
  endtask

  task automatic set_req(int k, int s, int t, int d, int f, int i);
    req_valid = 1'b1;
    kind = 3'(k); rs = 5'(s); rt = 5'(t); rd = 5'(d); funct = 6'(f); imm = 16'(i);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_log();
  endtask

  task automatic send(int k, int s, int t, int d, int f, int i);
    bit got;
    got = 0;
    set_req(k, s, t, d, f, i);
    for (int n = 0; n < 10 && !got; n++) begin
      tick();
      got = last_acc;
    end
    if (!got) chk("handshake_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; req_valid = 1'b0;
    kind = 3'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; funct = 6'd0; imm = 16'd0;
    model_reset();
    tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_data", wr_data, 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // ADDI into address 0
    do_start();
    send(3, 0, 1, 0, 0, 5);
    tick();
    tick();
    chk("addi_writes", 32'(log_data.size()), 32'd1);
    if (log_data.size() >= 1) begin
      chk("addi_addr", 32'(log_addr[0]), 32'd0);
      chk("addi_data", log_data[0], 32'h20010005);
    end
    chk("addi_count", 32'(word_count), 32'd1);

    // back-to-back R then BEQ
    do_start();
    send(0, 1, 2, 3, 'h20, 0);
    send(1, 1, 2, 0, 0, 3);
    tick();
    tick();
    chk("b2b_writes", 32'(log_data.size()), 32'd2);
    if (log_data.size() >= 2) begin
      chk("r_data", log_data[0], 32'h00221820);
      chk("r_addr", 32'(log_addr[0]), 32'd0);
      chk("beq_data", log_data[1], 32'h10220003);
      chk("beq_addr", 32'(log_addr[1]), 32'd1);
      chk("b2b_spacing", 32'(log_cyc[1] - log_cyc[0]), 32'd1);
    end

    // LUI ignores rs, then ORI
    do_start();
    send(4, 7, 4, 0, 0, 'h1234);
    send(5, 4, 5, 0, 0, 'h00FF);
    tick();
    tick();
    chk("lui_ori_writes", 32'(log_data.size()), 32'd2);
    if (log_data.size() >= 2) begin
      chk("lui_data", log_data[0], 32'h3C041234);
      chk("ori_data", log_data[1], 32'h348500FF);
    end

    // valid held for six requests: only DEPTH get in
    do_start();
    n_acc = 0;
    set_req(3, 2, 3, 0, 0, 'h100);
    for (int n = 0; n < 10; n++) begin
      tick();
      if (last_acc) begin
        n_acc++;
        if (n_acc >= 6) req_valid = 1'b0;
        else imm = imm + 16'd1;
      end
    end
    req_valid = 1'b0;
    chk("full_accepts", 32'(n_acc), 32'(DEPTH));
    chk("full_writes", 32'(log_data.size()), 32'(DEPTH));
    for (int n = 0; n < log_addr.size(); n++) chk("full_addr", 32'(log_addr[n]), 32'(n));
    chk("full_flag", 32'(full), 32'd1);
    chk("full_done", 32'(done), 32'd1);
    chk("full_ready", 32'(req_ready), 32'd0);

    // illegal kind between legal ones, finish alongside the last request
    do_start();
    send(3, 1, 2, 0, 0, 'h11);
    send(7, 1, 2, 3, 4, 5);
    set_req(0, 4, 5, 6, 'h25, 0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    req_valid = 1'b0;
    chk("fin_accept", 32'(last_acc), 32'd1);
    tick();
    tick();
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_writes", 32'(log_data.size()), 32'd2);
    if (log_data.size() >= 2) begin
      chk("ill_addr0", 32'(log_addr[0]), 32'd0);
      chk("ill_addr1", 32'(log_addr[1]), 32'd1);
      chk("fin_done_with_write", 32'(log_done[1]), 32'd1);
      chk("fin_not_done_before", 32'(log_done[0]), 32'd0);
    end

    // checksum of two words, then reset in the middle of a write
    do_start();
    send(3, 0, 1, 0, 0, 5);
    send(0, 1, 2, 3, 'h20, 0);
    tick();
    tick();
    chk("csum_pair", checksum, exp_csum(32'h20231825));
    send(3, 9, 9, 0, 0, 'h77);
    chk("prerst_wr_en", 32'(wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_addr", 32'(wr_addr), 32'd0);
    chk("arst_data", wr_data, 32'd0);
    chk("arst_count", 32'(word_count), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_csum", checksum, 32'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();

    // random traffic against the model
    for (int n = 0; n < 800; n++) begin
      start     = ($urandom_range(0, 11) == 0);
      finish    = ($urandom_range(0, 24) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      kind      = 3'($urandom_range(0, 7));
      rs        = 5'($urandom);
      rt        = 5'($urandom);
      rd        = 5'($urandom);
      funct     = 6'($urandom);
      imm       = 16'($urandom);
      rst_n     = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1; start = 1'b0; finish = 1'b0; req_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
